// File: rtl/pll_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pll_ctrl_pkg
// Shared definitions for the PLL reset sequencer: controller state encoding,
// lock-loss counter width and a helper that sizes the shared cycle counter.
// ---------------------------------------------------------------------------
package pll_ctrl_pkg;

  localparam int unsigned LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_FILT   = 3'd2,
    ST_REL    = 3'd3,
    ST_RUN    = 3'd4,
    ST_FAULT  = 3'd5
  } pll_state_e;

  // Width needed for one counter to reach the largest of four terminal counts.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c,
                                            input int unsigned d);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_lock_sync.sv
// ---------------------------------------------------------------------------
// pll_lock_sync
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the
// reference clock domain. Both flops clear to 0 on reset so a lock is never
// assumed until it has actually been observed.
//   clk       in  reference clock
//   rst_n     in  asynchronous active-low reset
//   async_in  in  asynchronous input
//   sync_out  out synchronized output (2 clk latency)
// ---------------------------------------------------------------------------
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl
// Sequences PLL reset, waits for a filtered lock, then releases N_DOM
// downstream active-low resets one at a time, STAGE_GAP cycles apart.
// Repeated lock timeouts end in a sticky FAULT; lock loss after release
// re-asserts all downstream resets and restarts the PLL.
//
// Optional feature: define PLL_RESET_CTRL_LOSS_CNT_EN to implement the
// saturating lock-loss counter; otherwise lock_loss_cnt is tied to 0.
//
// Ports
//   clk            in   free-running reference clock
//   rst_n          in   asynchronous active-low reset
//   pll_locked     in   PLL lock flag (asynchronous)
//   clear_fault    in   single-cycle pulse, leaves FAULT
//   pll_rst        out  active-high PLL reset
//   sys_rst_n      out  per-domain active-low resets, bit 0 first
//   ready          out  high in RUN
//   fault          out  high in FAULT
//   lock_loss_cnt  out  saturating lock-loss count
// ---------------------------------------------------------------------------
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned N_DOM          = 5,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned STAGE_GAP      = 8,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  clear_fault,
  output logic                  pll_rst,
  output logic [N_DOM-1:0]      sys_rst_n,
  output logic                  ready,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned REL_CYCLES = N_DOM * STAGE_GAP;
  localparam int unsigned CNT_W      = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                                 LOCK_STABLE, REL_CYCLES);
  localparam int unsigned RETRY_W    = $clog2(MAX_RETRY + 1) + 1;

  logic lk;

  pll_lock_sync u_lock_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pll_locked),
    .sync_out (lk)
  );

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic [N_DOM-1:0]   sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               loss_evt;

  // One counter serves every timed state; it is cleared on each transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    retry_d  = retry_q;
    loss_evt = 1'b0;
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (lk) begin
          state_d = ST_FILT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_q >= RETRY_W'(MAX_RETRY)) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_PLLRST;
          end
        end
      end
      ST_FILT: begin
        if (!lk) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          state_d = ST_REL;
          cnt_d   = '0;
        end
      end
      ST_REL: begin
        if (!lk) begin
          state_d  = ST_PLLRST;
          cnt_d    = '0;
          loss_evt = 1'b1;
        end else if (cnt_q == CNT_W'(REL_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d   = '0;
        retry_d = '0;
        if (!lk) begin
          state_d  = ST_PLLRST;
          loss_evt = 1'b1;
        end
      end
      ST_FAULT: begin
        cnt_d = '0;
        if (clear_fault) begin
          state_d = ST_PLLRST;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_PLLRST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // flop tracks state_q exactly and cannot glitch.
  always_comb begin
    pll_rst_d   = (state_d == ST_PLLRST) || (state_d == ST_FAULT);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
    sys_rst_n_d = '0;
    if (state_d == ST_RUN) begin
      sys_rst_n_d = '1;
    end else if (state_d == ST_REL) begin
      // Released bits are held; a new bit opens each STAGE_GAP boundary.
      sys_rst_n_d = (state_q == ST_REL) ? sys_rst_n_q : '0;
      for (int unsigned i = 0; i < N_DOM; i++) begin
        if (cnt_d == CNT_W'(i * STAGE_GAP)) sys_rst_n_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLLRST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;

`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_evt && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) loss_cnt_q <= '0;
    else        loss_cnt_q <= loss_cnt_d;
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  logic unused_loss_evt;
  assign unused_loss_evt = loss_evt;
  assign lock_loss_cnt   = '0;
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_ctrl
// Directed bench for pll_reset_ctrl. u_dut uses default timing except a
// shortened LOCK_TIMEOUT (200) so the retry/fault path stays short; u_fast
// uses tiny timings so many lock-loss cycles fit in a short run.
// Expected lock_loss_cnt follows PLL_RESET_CTRL_LOSS_CNT_EN.
// ---------------------------------------------------------------------------
module tb_pll_reset_ctrl;

`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, pll_locked, clear_fault;
  logic       pll_rst, ready, fault;
  logic [4:0] sys_rst_n;
  logic [7:0] lock_loss_cnt;

  logic       f_rst_n, f_locked, f_clear;
  logic       f_pll_rst, f_ready, f_fault;
  logic [1:0] f_sys_rst_n;
  logic [7:0] f_loss;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_reset_ctrl #(
    .N_DOM(5), .PLL_RST_CYCLES(16), .LOCK_TIMEOUT(200),
    .LOCK_STABLE(1024), .STAGE_GAP(8), .MAX_RETRY(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .clear_fault(clear_fault),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
    .lock_loss_cnt(lock_loss_cnt)
  );

  pll_reset_ctrl #(
    .N_DOM(2), .PLL_RST_CYCLES(2), .LOCK_TIMEOUT(16),
    .LOCK_STABLE(2), .STAGE_GAP(1), .MAX_RETRY(3)
  ) u_fast (
    .clk(clk), .rst_n(f_rst_n), .pll_locked(f_locked), .clear_fault(f_clear),
    .pll_rst(f_pll_rst), .sys_rst_n(f_sys_rst_n), .ready(f_ready), .fault(f_fault),
    .lock_loss_cnt(f_loss)
  );

  task automatic apply_reset(input logic lock_val);
    rst_n       = 1'b0;
    pll_locked  = lock_val;
    clear_fault = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    checks++;
    if ({pll_rst, sys_rst_n, ready, fault, lock_loss_cnt} !== {1'b1, 5'b0, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_values: got pll_rst=%b sys=%b rdy=%b flt=%b cnt=%0d expected 1 00000 0 0 0",
               pll_rst, sys_rst_n, ready, fault, lock_loss_cnt);
    end
  endtask

  task automatic test_startup();
    int hi_cnt = 0, fall_cyc = -1, ready_cyc = -1;
    int rise[5] = '{-1, -1, -1, -1, -1};
    apply_reset(1'b0);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (cyc == 20) pll_locked = 1'b1;
      if (pll_rst) hi_cnt++;
      else if (fall_cyc < 0) fall_cyc = cyc;
      for (int i = 0; i < 5; i++) if (sys_rst_n[i] && rise[i] < 0) rise[i] = cyc;
      if (ready) begin
        ready_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (hi_cnt !== 16) begin
      failures++;
      $display("FAIL startup_pll_rst_width: got %0d expected 16", hi_cnt);
    end
    checks++;
    if (fall_cyc !== 16) begin
      failures++;
      $display("FAIL startup_pll_rst_fall: got %0d expected 16", fall_cyc);
    end
    // lock set at cycle 20: 2 sync + 1 WAIT decision + 1024 filter cycles
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rise[i] !== 1047 + 8 * i) begin
        failures++;
        $display("FAIL startup_sys_rst_n%0d_rise: got %0d expected %0d", i, rise[i], 1047 + 8 * i);
      end
    end
    checks++;
    if (ready_cyc !== 1087) begin
      failures++;
      $display("FAIL startup_ready_cycle: got %0d expected 1087", ready_cyc);
    end
    // clear_fault outside FAULT has no effect
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready, fault, pll_rst, sys_rst_n} !== {1'b1, 1'b0, 1'b0, 5'b11111}) begin
      failures++;
      $display("FAIL clear_fault_ignored: got rdy=%b flt=%b pll_rst=%b sys=%b expected 1 0 0 11111",
               ready, fault, pll_rst, sys_rst_n);
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL lock_loss_latency_early: got ready=%b expected 1", ready);
    end
    @(negedge clk);
    checks++;
    if ({sys_rst_n, ready, pll_rst} !== {5'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL lock_loss_outputs: got sys=%b rdy=%b pll_rst=%b expected 00000 0 1",
               sys_rst_n, ready, pll_rst);
    end
    checks++;
    if (lock_loss_cnt !== (LOSS_EN ? 8'd1 : 8'd0)) begin
      failures++;
      $display("FAIL lock_loss_count: got %0d expected %0d", lock_loss_cnt, LOSS_EN ? 1 : 0);
    end
    pll_locked = 1'b1;
  endtask

  task automatic test_filt_glitch();
    int rise0 = -1;
    apply_reset(1'b1);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 1700; cyc++) begin
      // low for exactly one sampled cycle while the filter count is 500
      if (cyc == 515) pll_locked = 1'b0;
      if (cyc == 516) pll_locked = 1'b1;
      if (sys_rst_n[0]) begin
        rise0 = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (rise0 !== 1543) begin
      failures++;
      $display("FAIL filt_restart_release: got %0d expected 1543", rise0);
    end
  endtask

  task automatic test_reset_mid_rel();
    int hi_cnt = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (sys_rst_n[1]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen || sys_rst_n !== 5'b00011) begin
      failures++;
      $display("FAIL mid_rel_two_released: got sys=%b seen=%0d expected 00011 1", sys_rst_n, seen);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_rst, sys_rst_n, ready, fault, lock_loss_cnt} !== {1'b1, 5'b0, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL async_reset_mid_rel: got pll_rst=%b sys=%b rdy=%b flt=%b cnt=%0d expected 1 00000 0 0 0",
               pll_rst, sys_rst_n, ready, fault, lock_loss_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!pll_rst) break;
      hi_cnt++;
      @(negedge clk);
    end
    checks++;
    if (hi_cnt !== 16) begin
      failures++;
      $display("FAIL restart_pulse_width: got %0d expected 16", hi_cnt);
    end
  endtask

  task automatic test_fault();
    int pulses = 0, fault_cyc = -1, fall_k = -1, fault_k = -1;
    logic prev = 1'b0;
    apply_reset(1'b0);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (fault) begin
        fault_cyc = cyc;
        break;
      end
      if (pll_rst && !prev) pulses++;
      prev = pll_rst;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 4) begin
      failures++;
      $display("FAIL fault_pulse_count: got %0d expected 4", pulses);
    end
    checks++;
    if (fault_cyc !== 864) begin
      failures++;
      $display("FAIL fault_entry_cycle: got %0d expected 864", fault_cyc);
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({fault, pll_rst, sys_rst_n, ready} !== {1'b1, 1'b1, 5'b0, 1'b0}) begin
      failures++;
      $display("FAIL fault_sticky: got flt=%b pll_rst=%b sys=%b rdy=%b expected 1 1 00000 0",
               fault, pll_rst, sys_rst_n, ready);
    end
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    checks++;
    if ({fault, pll_rst} !== 2'b01) begin
      failures++;
      $display("FAIL clear_fault_exit: got flt=%b pll_rst=%b expected 0 1", fault, pll_rst);
    end
    // retry count restarts from zero: the full four-pulse sequence repeats
    for (int k = 0; k < 1000; k++) begin
      if (!pll_rst && fall_k < 0) fall_k = k;
      if (fault) begin
        fault_k = k;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (fall_k !== 16) begin
      failures++;
      $display("FAIL clear_fault_pulse_width: got %0d expected 16", fall_k);
    end
    checks++;
    if (fault_k !== 864) begin
      failures++;
      $display("FAIL retry_cleared_refault: got %0d expected 864", fault_k);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    f_locked = 1'b1;
    @(negedge clk);
    f_rst_n = 1'b1;
    for (int n = 1; n <= 260; n++) begin
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (f_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL sat_reach_run: got ready=0 after 200 cycles, loss %0d, expected 1", n);
        break;
      end
      f_locked = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (!f_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      f_locked = 1'b1;
      if (n == 1 || n == 255 || n == 256 || n == 260) begin
        checks++;
        if (!ok || {f_pll_rst, f_sys_rst_n} !== 3'b100) begin
          failures++;
          $display("FAIL sat_loss_outputs_%0d: got ok=%0d pll_rst=%b sys=%b expected 1 1 00",
                   n, ok, f_pll_rst, f_sys_rst_n);
        end
        checks++;
        if (f_loss !== (LOSS_EN ? ((n > 255) ? 8'd255 : 8'(n)) : 8'd0)) begin
          failures++;
          $display("FAIL sat_count_%0d: got %0d expected %0d", n, f_loss,
                   LOSS_EN ? ((n > 255) ? 255 : n) : 0);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; clear_fault = 1'b0;
    f_rst_n = 1'b0; f_locked = 1'b0; f_clear = 1'b0;
    test_reset();
    test_startup();
    test_lock_loss();
    test_filt_glitch();
    test_reset_mid_rel();
    test_fault();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pll_reset_ctrl.md
PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 Parameter N_DOM, default 5: number of downstream clock domains receiving a sequenced reset.
REQ-002 Parameter PLL_RST_CYCLES, default 16: width in clk cycles of each pll_rst pulse.
REQ-003 Parameter LOCK_TIMEOUT, default 65536: clk cycles allowed for lock after pll_rst deasserts.
REQ-004 Parameter LOCK_STABLE, default 1024: clk cycles synchronized lock must stay high before release.
REQ-005 Parameter STAGE_GAP, default 8: clk cycles between successive domain reset releases.
REQ-006 Parameter MAX_RETRY, default 3: consecutive lock timeouts tolerated before fault.
REQ-007 clk  in  1  free-running reference clock, never PLL-derived.
REQ-008 rst_n  in  1  asynchronous active-low reset, deassertion synchronous to clk.
REQ-009 pll_locked  in  1  PLL lock indicator, asynchronous to clk.
REQ-010 clear_fault  in  1  single-cycle pulse leaving FAULT.
REQ-011 pll_rst  out  1  active-high reset to the PLL.
REQ-012 sys_rst_n  out  N_DOM  per-domain active-low resets, bit 0 released first.
REQ-013 ready  out  1  high only in RUN.
REQ-014 fault  out  1  high only in FAULT.
REQ-015 lock_loss_cnt  out  8  saturating count of lock losses seen in REL or RUN.

Function
REQ-016 pll_locked SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (lk).
REQ-017 FSM states SHALL be PLLRST, WAIT, FILT, REL, RUN, FAULT.
REQ-018 PLLRST: pll_rst=1, sys_rst_n all 0; after exactly PLL_RST_CYCLES cycles -> WAIT.
REQ-019 WAIT: pll_rst=0; lk=1 -> FILT; timeout counter reaching LOCK_TIMEOUT with lk=0 -> retry+1, then PLLRST, or FAULT if retry would exceed MAX_RETRY.
REQ-020 FILT: lk=0 on any cycle -> WAIT with timeout counter cleared; LOCK_STABLE consecutive lk=1 cycles -> REL.
REQ-021 REL: sys_rst_n[0] rises first cycle in REL; sys_rst_n[i] rises i*STAGE_GAP cycles later; STAGE_GAP cycles after last release -> RUN.
REQ-022 RUN: ready=1, retry counter cleared, all sys_rst_n high.
REQ-023 lk=0 in REL or RUN: next cycle all sys_rst_n=0, ready=0, lock_loss_cnt+1 (saturates at 255), -> PLLRST.
REQ-024 FAULT: pll_rst=1, sys_rst_n all 0, fault=1; sticky until clear_fault=1 -> PLLRST with retry cleared.
REQ-025 clear_fault outside FAULT SHALL be ignored.
REQ-026 sys_rst_n bits, once released, SHALL stay high until lock loss or reset; no glitches on any output (all registered).

Reset
REQ-027 rst_n low SHALL asynchronously force: state PLLRST, pll_rst=1, sys_rst_n=0, ready=0, fault=0, lock_loss_cnt=0, all counters and synchronizer flops 0.
REQ-028 rst_n assertion mid-sequence SHALL abort any state immediately; full PLL_RST_CYCLES pulse restarts after deassertion.

Configuration
REQ-029 Macro PLL_RESET_CTRL_LOSS_CNT_EN defined: lock_loss_cnt counter implemented per REQ-023.
REQ-030 Macro undefined: port retained, lock_loss_cnt tied to 0, no counter logic; FSM behaviour unchanged.

Structure
REQ-031 Shared package pll_ctrl_pkg SHALL hold the state enum type and lock_loss_cnt width constant.
REQ-032 Synchronizer SHALL be sub-module pll_lock_sync (2-flop, reset to 0); all else in one module.

Verification
REQ-033 Defaults; rst_n released, pll_locked=1 from cycle 20 -> pll_rst high 16 cycles, FILT 1024 cycles, sys_rst_n[0..4] rise 8 apart, ready 8 cycles after bit 4.
REQ-034 pll_locked held 0 -> exactly 4 pll_rst pulses (initial + 3 retries), then fault=1; clear_fault pulse -> fault=0, pll_rst pulse restarts.
REQ-035 pll_locked drops 1 cycle at FILT count 500 -> returns to WAIT, filter restarts, REL only after 1024 fresh stable cycles.
REQ-036 In RUN, pll_locked low -> within 3 cycles all sys_rst_n=0, ready=0, lock_loss_cnt=1, pll_rst pulses; 256 losses -> count holds 255.
REQ-037 rst_n asserted during REL after 2 domains released -> all outputs at reset values same cycle, asynchronously.
REQ-038 Build without PLL_RESET_CTRL_LOSS_CNT_EN, repeat REQ-036 -> lock_loss_cnt stays 0, other outputs identical.
